// File: rtl/mure_retire_sched.sv
// Retirement scheduler: drains the per-port uop FIFOs and the common FIFO, serialising each group into
// single-beat trace records. Define MURE_SCHED_STALL_CNT_EN to add the stall_cnt_o back-pressure counter.

package mure_pkg;
   localparam int unsigned XLEN      = 32;
   localparam int unsigned INST_LEN  = 32;
   localparam int unsigned CAUSE_LEN = 5;

   typedef struct packed {
      logic                 valid;
      logic                 iretired;
      logic                 exception;
      logic                 interrupt;
      logic                 eret;
      logic [INST_LEN-1:0]  inst_data;
      logic [XLEN-1:0]      pc;
      logic [XLEN-1:0]      epc;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
   } beat_t;
endpackage

module mure_retire_sched
   import mure_pkg::*;
#(
   parameter int unsigned NrRetiredInstr = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               cmn_empty_i,
   input  logic [NrRetiredInstr-1:0]          cmn_valids_i,
   input  logic                               cmn_exc_i,
   input  logic                               cmn_int_i,
   input  logic                               cmn_eret_i,
   input  logic [CAUSE_LEN-1:0]               cmn_cause_i,
   input  logic [XLEN-1:0]                    cmn_tval_i,
   output logic                               cmn_pop_o,
   input  logic [NrRetiredInstr-1:0]          uop_empty_i,
   input  logic [NrRetiredInstr*XLEN-1:0]     uop_pc_i,
   input  logic [NrRetiredInstr*INST_LEN-1:0] uop_instr_i,
   output logic [NrRetiredInstr-1:0]          uop_pop_o,
   input  logic                               enc_ready_i,
   output logic                               beat_valid_o,
   output logic                               iretired_o,
   output logic                               exception_o,
   output logic                               interrupt_o,
   output logic                               eret_o,
   output logic [INST_LEN-1:0]                inst_data_o,
   output logic [XLEN-1:0]                    pc_o,
   output logic [XLEN-1:0]                    epc_o,
   output logic [CAUSE_LEN-1:0]               cause_o,
   output logic [XLEN-1:0]                    tval_o
`ifdef MURE_SCHED_STALL_CNT_EN
   ,
   output logic [15:0]                        stall_cnt_o
`endif
);

   localparam int unsigned IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_TRAP
   } state_e;

   typedef struct packed {
      logic [NrRetiredInstr-1:0] mask;
      logic                      exc;
      logic                      irq;
      logic                      eret;
      logic [CAUSE_LEN-1:0]      cause;
      logic [XLEN-1:0]           tval;
   } ctx_t;

   state_e              state_q, state_d;
   ctx_t                ctx_q, ctx_d;
   logic [XLEN-1:0]     last_pc_q, last_pc_d;
   beat_t               beat_q, beat_d;
   logic                slot_free;
   logic [IdxW-1:0]     sel_idx;
   logic [XLEN-1:0]     sel_pc;
   logic [INST_LEN-1:0] sel_instr;
   logic                sel_empty;

   assign slot_free = !beat_q.valid || enc_ready_i;

   // Lowest pending port wins: scanning downwards lets the last hit be the lowest index.
   always_comb begin
      sel_idx   = '0;
      sel_pc    = '0;
      sel_instr = '0;
      sel_empty = 1'b1;
      for (int i = int'(NrRetiredInstr) - 1; i >= 0; i--) begin
         if (ctx_q.mask[i]) begin
            sel_idx   = IdxW'(i);
            sel_pc    = uop_pc_i[i*XLEN +: XLEN];
            sel_instr = uop_instr_i[i*INST_LEN +: INST_LEN];
            sel_empty = uop_empty_i[i];
         end
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves a signal unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      ctx_d     = ctx_q;
      last_pc_d = last_pc_q;
      cmn_pop_o = 1'b0;
      uop_pop_o = '0;
      beat_d    = slot_free ? '0 : beat_q;

      unique case (state_q)
         S_IDLE: begin
            if (!cmn_empty_i) begin
               cmn_pop_o   = 1'b1;
               ctx_d.mask  = cmn_valids_i;
               ctx_d.exc   = cmn_exc_i;
               ctx_d.irq   = cmn_int_i;
               ctx_d.eret  = cmn_eret_i;
               ctx_d.cause = cmn_cause_i;
               ctx_d.tval  = cmn_tval_i;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (ctx_q.mask == '0) begin
               state_d = (ctx_q.exc || ctx_q.irq) ? S_TRAP : S_IDLE;
            end else if (slot_free && !sel_empty) begin
               // NOTE: blocking '=' here, so ctx_d.mask below already sees the bit just cleared.
               uop_pop_o[sel_idx]  = 1'b1;
               ctx_d.mask[sel_idx] = 1'b0;
               last_pc_d           = sel_pc;
               beat_d              = '0;
               beat_d.valid        = 1'b1;
               beat_d.iretired     = 1'b1;
               beat_d.inst_data    = sel_instr;
               beat_d.pc           = sel_pc;
               beat_d.eret         = ctx_q.eret && (ctx_d.mask == '0);
               if (ctx_d.mask == '0) begin
                  state_d = (ctx_q.exc || ctx_q.irq) ? S_TRAP : S_IDLE;
               end
            end
         end
         S_TRAP: begin
            if (slot_free) begin
               beat_d           = '0;
               beat_d.valid     = 1'b1;
               beat_d.interrupt = ctx_q.irq;
               beat_d.exception = ctx_q.exc && !ctx_q.irq;
               beat_d.epc       = last_pc_q;
               beat_d.cause     = ctx_q.cause;
               beat_d.tval      = ctx_q.tval;
               state_d          = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         ctx_q     <= '0;
         last_pc_q <= '0;
         beat_q    <= '0;
      end else begin
         state_q   <= state_d;
         ctx_q     <= ctx_d;
         last_pc_q <= last_pc_d;
         beat_q    <= beat_d;
      end
   end

   assign beat_valid_o = beat_q.valid;
   assign iretired_o   = beat_q.iretired;
   assign exception_o  = beat_q.exception;
   assign interrupt_o  = beat_q.interrupt;
   assign eret_o       = beat_q.eret;
   assign inst_data_o  = beat_q.inst_data;
   assign pc_o         = beat_q.pc;
   assign epc_o        = beat_q.epc;
   assign cause_o      = beat_q.cause;
   assign tval_o       = beat_q.tval;

`ifdef MURE_SCHED_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else if (beat_q.valid && !enc_ready_i && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   // Stall counter not built.
`endif

endmodule

// File: tb/tb_mure_retire_sched.sv
// Directed bench for mure_retire_sched: behavioural FIFOs answer the pops, beats are checked per cycle.
// Define MURE_SCHED_STALL_CNT_EN for both files to also check stall_cnt_o.

module tb_mure_retire_sched;
   import mure_pkg::*;

   typedef struct {
      logic [1:0]           valids;
      logic                 exc;
      logic                 irq;
      logic                 eret;
      logic [CAUSE_LEN-1:0] cause;
      logic [XLEN-1:0]      tval;
   } grp_t;

   typedef struct {
      logic [XLEN-1:0]     pc;
      logic [INST_LEN-1:0] instr;
   } uop_t;

   logic                 clk_i = 1'b0;
   logic                 rst_ni;
   logic                 cmn_empty_i;
   logic [1:0]           cmn_valids_i;
   logic                 cmn_exc_i, cmn_int_i, cmn_eret_i;
   logic [CAUSE_LEN-1:0] cmn_cause_i;
   logic [XLEN-1:0]      cmn_tval_i;
   logic                 cmn_pop_o;
   logic [1:0]           uop_empty_i;
   logic [2*XLEN-1:0]    uop_pc_i;
   logic [2*INST_LEN-1:0] uop_instr_i;
   logic [1:0]           uop_pop_o;
   logic                 enc_ready_i;
   logic                 beat_valid_o, iretired_o, exception_o, interrupt_o, eret_o;
   logic [INST_LEN-1:0]  inst_data_o;
   logic [XLEN-1:0]      pc_o, epc_o, tval_o;
   logic [CAUSE_LEN-1:0] cause_o;
`ifdef MURE_SCHED_STALL_CNT_EN
   logic [15:0]          stall_cnt_o;
`endif

   grp_t cq[$];
   uop_t uq0[$];
   uop_t uq1[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk_i = ~clk_i;

   mure_retire_sched #(.NrRetiredInstr(2)) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .cmn_empty_i(cmn_empty_i),
      .cmn_valids_i(cmn_valids_i),
      .cmn_exc_i(cmn_exc_i),
      .cmn_int_i(cmn_int_i),
      .cmn_eret_i(cmn_eret_i),
      .cmn_cause_i(cmn_cause_i),
      .cmn_tval_i(cmn_tval_i),
      .cmn_pop_o(cmn_pop_o),
      .uop_empty_i(uop_empty_i),
      .uop_pc_i(uop_pc_i),
      .uop_instr_i(uop_instr_i),
      .uop_pop_o(uop_pop_o),
      .enc_ready_i(enc_ready_i),
      .beat_valid_o(beat_valid_o),
      .iretired_o(iretired_o),
      .exception_o(exception_o),
      .interrupt_o(interrupt_o),
      .eret_o(eret_o),
      .inst_data_o(inst_data_o),
      .pc_o(pc_o),
      .epc_o(epc_o),
      .cause_o(cause_o),
      .tval_o(tval_o)
`ifdef MURE_SCHED_STALL_CNT_EN
      ,
      .stall_cnt_o(stall_cnt_o)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_beat(input string tag, input logic ir, input logic ex, input logic it,
                             input logic er, input logic [31:0] ins, input logic [31:0] pc,
                             input logic [31:0] epc, input logic [4:0] cause, input logic [31:0] tval);
      check({tag, "_valid"}, beat_valid_o, 1'b1);
      check({tag, "_iret"},  iretired_o,   ir);
      check({tag, "_exc"},   exception_o,  ex);
      check({tag, "_int"},   interrupt_o,  it);
      check({tag, "_eret"},  eret_o,       er);
      check({tag, "_inst"},  inst_data_o,  ins);
      check({tag, "_pc"},    pc_o,         pc);
      check({tag, "_epc"},   epc_o,        epc);
      check({tag, "_cause"}, cause_o,      cause);
      check({tag, "_tval"},  tval_o,       tval);
   endtask

   task automatic refresh();
      cmn_empty_i = (cq.size() == 0);
      if (cq.size() != 0) begin
         cmn_valids_i = cq[0].valids;
         cmn_exc_i    = cq[0].exc;
         cmn_int_i    = cq[0].irq;
         cmn_eret_i   = cq[0].eret;
         cmn_cause_i  = cq[0].cause;
         cmn_tval_i   = cq[0].tval;
      end else begin
         cmn_valids_i = '0;
         {cmn_exc_i, cmn_int_i, cmn_eret_i} = '0;
         cmn_cause_i  = '0;
         cmn_tval_i   = '0;
      end
      uop_empty_i[0] = (uq0.size() == 0);
      uop_empty_i[1] = (uq1.size() == 0);
      uop_pc_i[0 +: XLEN]        = (uq0.size() != 0) ? uq0[0].pc    : '0;
      uop_instr_i[0 +: INST_LEN] = (uq0.size() != 0) ? uq0[0].instr : '0;
      uop_pc_i[XLEN +: XLEN]         = (uq1.size() != 0) ? uq1[0].pc    : '0;
      uop_instr_i[INST_LEN +: INST_LEN] = (uq1.size() != 0) ? uq1[0].instr : '0;
   endtask

   // One clock: pops seen before the edge are applied to the model FIFOs after it.
   task automatic tick();
      logic       p_cmn;
      logic [1:0] p_uop;
      p_cmn = cmn_pop_o;
      p_uop = uop_pop_o;
      if (p_cmn) check("cmn_pop_nonempty", cq.size() != 0, 1'b1);
      if (p_uop != 2'b00) check("uop_pop_onehot", $onehot(p_uop), 1'b1);
      if (p_uop[0]) check("uop0_pop_nonempty", uq0.size() != 0, 1'b1);
      if (p_uop[1]) check("uop1_pop_nonempty", uq1.size() != 0, 1'b1);
      @(posedge clk_i);
      #1;
      if (p_cmn && cq.size() != 0) void'(cq.pop_front());
      if (p_uop[0] && uq0.size() != 0) void'(uq0.pop_front());
      if (p_uop[1] && uq1.size() != 0) void'(uq1.pop_front());
      refresh();
      #1;
   endtask

   task automatic push_grp(input logic [1:0] v, input logic e, input logic i, input logic r,
                           input logic [4:0] c, input logic [31:0] tv);
      grp_t g;
      g.valids = v; g.exc = e; g.irq = i; g.eret = r; g.cause = c; g.tval = tv;
      cq.push_back(g);
   endtask

   task automatic push_uop(input int port, input logic [31:0] pc, input logic [31:0] ins);
      uop_t u;
      u.pc = pc; u.instr = ins;
      if (port == 0) uq0.push_back(u);
      else uq1.push_back(u);
   endtask

   task automatic start_group(input string tag);
      refresh();
      #1;
      check({tag, "_cmn_pop"}, cmn_pop_o, 1'b1);
   endtask

   initial begin
      rst_ni      = 1'b0;
      enc_ready_i = 1'b1;
      refresh();
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_valid", beat_valid_o, 1'b0);
      check("rst_pc", pc_o, 32'h0);
      check("rst_epc", epc_o, 32'h0);
      check("rst_flags", {iretired_o, exception_o, interrupt_o, eret_o}, 4'h0);
      check("rst_pops", {cmn_pop_o, uop_pop_o}, 3'b000);
      rst_ni = 1'b1;
      #1;

      // Two-instruction group, no trap.
      push_uop(0, 32'h100, 32'hA0);
      push_uop(1, 32'h104, 32'hA1);
      push_grp(2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      start_group("g1");
      check("g1_t0_uop_pop", uop_pop_o, 2'b00);
      tick();
      check("g1_t1_valid", beat_valid_o, 1'b0);
      check("g1_t1_uop_pop", uop_pop_o, 2'b01);
      tick();
      check_beat("g1_b0", 1, 0, 0, 0, 32'hA0, 32'h100, 0, 0, 0);
      check("g1_t2_uop_pop", uop_pop_o, 2'b10);
      tick();
      check_beat("g1_b1", 1, 0, 0, 0, 32'hA1, 32'h104, 0, 0, 0);
      check("g1_t3_uop_pop", uop_pop_o, 2'b00);
      tick();
      check("g1_t4_valid", beat_valid_o, 1'b0);

      // One instruction followed by an exception trap beat.
      push_uop(0, 32'h200, 32'hB0);
      push_grp(2'b01, 1'b1, 1'b0, 1'b0, 5'd2, 32'hDEAD);
      start_group("g2");
      tick();
      tick();
      check_beat("g2_b0", 1, 0, 0, 0, 32'hB0, 32'h200, 0, 0, 0);
      tick();
      check_beat("g2_trap", 0, 1, 0, 0, 0, 0, 32'h200, 5'd2, 32'hDEAD);
      tick();
      check("g2_t4_valid", beat_valid_o, 1'b0);

      // Encoder back-pressure on the first beat for three cycles.
      push_uop(0, 32'h100, 32'hC0);
      push_uop(1, 32'h104, 32'hC1);
      push_grp(2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      start_group("g3");
      tick();
      enc_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("g3_hold%0d_pc", k), pc_o, 32'h100);
         check($sformatf("g3_hold%0d_valid", k), beat_valid_o, 1'b1);
         check($sformatf("g3_hold%0d_pop", k), uop_pop_o, 2'b00);
      end
      tick();
      enc_ready_i = 1'b1;
      #1;
      check("g3_t5_pc", pc_o, 32'h100);
      check("g3_t5_pop", uop_pop_o, 2'b10);
      tick();
      check_beat("g3_b1", 1, 0, 0, 0, 32'hC1, 32'h104, 0, 0, 0);
`ifdef MURE_SCHED_STALL_CNT_EN
      check("g3_stall_cnt", stall_cnt_o, 16'd3);
`endif
      tick();
      check("g3_end_valid", beat_valid_o, 1'b0);

      // Port 1 uop FIFO empty for four cycles, group carries eret.
      push_grp(2'b10, 1'b0, 1'b0, 1'b1, 5'd0, 32'h0);
      start_group("g4");
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("g4_wait%0d_valid", k), beat_valid_o, 1'b0);
         check($sformatf("g4_wait%0d_pop", k), uop_pop_o, 2'b00);
      end
      tick();
      push_uop(1, 32'h300, 32'hD1);
      refresh();
      #1;
      check("g4_fill_pop", uop_pop_o, 2'b10);
      tick();
      check_beat("g4_b0", 1, 0, 0, 1, 32'hD1, 32'h300, 0, 0, 0);
      tick();

      // Empty mask with exc and int both set: trap beat only, interrupt wins, epc from earlier group.
      push_grp(2'b00, 1'b1, 1'b1, 1'b0, 5'd7, 32'h55);
      start_group("g5");
      tick();
      check("g5_t1_valid", beat_valid_o, 1'b0);
      tick();
      check("g5_t2_valid", beat_valid_o, 1'b0);
      check("g5_t2_pop", uop_pop_o, 2'b00);
      tick();
      check_beat("g5_trap", 0, 0, 1, 0, 0, 0, 32'h300, 5'd7, 32'h55);
      tick();

      // Empty mask, no trap: discarded.
      push_grp(2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      start_group("g6");
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("g6_t%0d_valid", k), beat_valid_o, 1'b0);
      end

      // Reset after the first beat of a two-instruction group.
      push_uop(0, 32'h400, 32'hE0);
      push_uop(1, 32'h404, 32'hE1);
      push_grp(2'b11, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      start_group("g7");
      tick();
      tick();
      check("g7_b0_pc", pc_o, 32'h400);
      rst_ni = 1'b0;
      #1;
      check("g7_rst_valid", beat_valid_o, 1'b0);
      check("g7_rst_pc", pc_o, 32'h0);
      check("g7_rst_inst", inst_data_o, 32'h0);
      check("g7_rst_pops", {cmn_pop_o, uop_pop_o}, 3'b000);
      cq.delete();
      uq0.delete();
      uq1.delete();
      refresh();
      tick();
      tick();
      rst_ni = 1'b1;
      #1;
      check("g7_idle_pop", cmn_pop_o, 1'b0);
      tick();
      check("g7_idle_valid", beat_valid_o, 1'b0);
      check("g7_idle_pop2", cmn_pop_o, 1'b0);
      push_uop(0, 32'h500, 32'hF0);
      push_grp(2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
      start_group("g8");
      tick();
      tick();
      check_beat("g8_b0", 1, 0, 0, 0, 32'hF0, 32'h500, 0, 0, 0);
      tick();
      check("g8_end_valid", beat_valid_o, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
